// File: rtl/cooler_pkg.sv
// cooler_pkg: shared widths, state encoding and constants for the cooler controllers
package cooler_pkg;
    localparam int SPEED_W = 12;
    localparam int TEMP_W  = 12;
    localparam logic [SPEED_W-1:0] SPEED_FULL = 12'hFFF;
    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_EMERG  = 2'd2,
        ST_KICK   = 2'd3
    } state_t;
endpackage

// File: rtl/cooler_tick_gen.sv
// cooler_tick_gen: free-running divider producing a one-clk control tick every DIV cycles
module cooler_tick_gen #(
    parameter int DIV = 5000000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick_o
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q;
    assign tick_o = cnt_q == LAST;
    // count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/cooler_speed_arbiter.sv
// cooler_speed_arbiter: arbitrates emergency, manual and auto fan-speed requests with kick and slew
module cooler_speed_arbiter
    import cooler_pkg::*;
#(
    parameter int                 TICK_DIV    = 5000000,
    parameter int                 STEP        = 16,
    parameter logic [TEMP_W-1:0]  TEMP_CRIT   = 12'd3200,
    parameter logic [TEMP_W-1:0]  TEMP_HYST   = 12'd128,
    parameter int                 MAN_TIMEOUT = 600,
    parameter logic [SPEED_W-1:0] KICK_SPEED  = 12'd2048,
    parameter int                 KICK_TICKS  = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [TEMP_W-1:0]  temp_i,
    input  logic [SPEED_W-1:0] auto_speed_i,
    input  logic               man_valid_i,
    input  logic [SPEED_W-1:0] man_speed_i,
    output logic               man_ready_o,
    input  logic               man_release_i,
    output logic [SPEED_W-1:0] speed_o,
    output logic [1:0]         mode_o,
    output logic               emerg_flag_o
);
    localparam int TW = $clog2(MAN_TIMEOUT + 1);
    localparam int KW = KICK_TICKS > 1 ? $clog2(KICK_TICKS + 1) : 1;
    localparam logic [TW-1:0]     TO_LAST   = TW'(MAN_TIMEOUT - 1);
    localparam logic [KW-1:0]     KICK_LAST = KW'(KICK_TICKS - 1);
    localparam logic [SPEED_W:0]  STEP_W    = (SPEED_W + 1)'(STEP);
    localparam logic [TEMP_W-1:0] EXIT_T    = TEMP_CRIT - TEMP_HYST;

    state_t               state_q, state_d, ret_q, ret_d, mode_sel;
    logic [SPEED_W-1:0]   speed_q, speed_d, man_target_q, man_target_d;
    logic [SPEED_W-1:0]   base, kick_val, target, slewed;
    logic [TW-1:0]        timeout_q, timeout_d;
    logic [KW-1:0]        kick_cnt_q, kick_cnt_d;
    logic signed [SPEED_W:0]   diff;
    logic [SPEED_W:0]          mag, step;
    logic signed [SPEED_W+1:0] sum;
    logic tick, accept, kick_go;

    cooler_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .tick_o (tick)
    );

    assign man_ready_o  = state_q == ST_AUTO || state_q == ST_MANUAL;
    assign accept       = man_valid_i && man_ready_o;
    assign speed_o      = speed_q;
    assign mode_o       = state_q;
    assign emerg_flag_o = state_q == ST_EMERG;

    // target selection and one slew step toward it, saturating to the speed range
    always_comb begin
        mode_sel = state_q == ST_KICK ? ret_q : state_q;
        base     = mode_sel == ST_MANUAL ? man_target_q : auto_speed_i;
        kick_val = base > KICK_SPEED ? base : KICK_SPEED;
        target   = state_q == ST_EMERG ? SPEED_FULL : state_q == ST_KICK ? kick_val : base;
        diff     = $signed({1'b0, target}) - $signed({1'b0, speed_q});
        mag      = diff[SPEED_W] ? $unsigned(-diff) : $unsigned(diff);
        step     = mag < STEP_W ? mag : STEP_W;
        sum      = $signed({2'b00, speed_q}) + (diff[SPEED_W] ? -$signed({1'b0, step}) : $signed({1'b0, step}));
        slewed   = sum[SPEED_W+1] ? '0 : sum[SPEED_W] ? SPEED_FULL : sum[SPEED_W-1:0];
        kick_go  = tick && speed_q == '0 && base != '0 && !accept;
    end

    // next-state: emergency first, then kick hold, then manual handshake/timeout and slew
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        speed_d      = speed_q;
        man_target_d = man_target_q;
        timeout_d    = timeout_q;
        kick_cnt_d   = kick_cnt_q;
        if (temp_i >= TEMP_CRIT) begin
            state_d    = ST_EMERG;
            speed_d    = SPEED_FULL;
            timeout_d  = '0;
            kick_cnt_d = '0;
        end else begin
            case (state_q)
                ST_EMERG: begin
                    speed_d = SPEED_FULL;
                    if (temp_i < EXIT_T) state_d = ST_AUTO;
                end
                ST_KICK: begin
                    speed_d = kick_val;
                    if (tick) begin
                        kick_cnt_d = kick_cnt_q + 1'b1;
                        if (kick_cnt_q == KICK_LAST) begin
                            state_d    = ret_q;
                            kick_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    if (tick) speed_d = kick_go ? kick_val : slewed;
                    if (accept) begin
                        state_d      = ST_MANUAL;
                        man_target_d = man_speed_i;
                        timeout_d    = '0;
                    end else if (kick_go) begin
                        state_d = ST_KICK;
                        ret_d   = state_q;
                    end else if (state_q == ST_MANUAL) begin
                        if (man_release_i) begin
                            state_d   = ST_AUTO;
                            timeout_d = '0;
                        end else if (tick) begin
                            timeout_d = timeout_q + 1'b1;
                            if (timeout_q == TO_LAST) begin
                                state_d   = ST_AUTO;
                                timeout_d = '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_AUTO;
            ret_q        <= ST_AUTO;
            speed_q      <= '0;
            man_target_q <= '0;
            timeout_q    <= '0;
            kick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            speed_q      <= speed_d;
            man_target_q <= man_target_d;
            timeout_q    <= timeout_d;
            kick_cnt_q   <= kick_cnt_d;
        end
    end
endmodule

// File: tb/tb_cooler_speed_arbiter.sv
// tb_cooler_speed_arbiter: directed vectors for kick, slew, manual handshake, emergency and async reset
module tb_cooler_speed_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] temp = 12'd1000;
    logic [11:0] auto_speed = 12'd100;
    logic        man_valid = 1'b0;
    logic [11:0] man_speed = 12'd0;
    logic        man_ready;
    logic        man_release = 1'b0;
    logic [11:0] speed;
    logic [1:0]  mode;
    logic        emerg_flag;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    cooler_speed_arbiter #(
        .TICK_DIV(5), .STEP(16), .TEMP_CRIT(12'd3200), .TEMP_HYST(12'd128),
        .MAN_TIMEOUT(4), .KICK_SPEED(12'd2048), .KICK_TICKS(2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .temp_i        (temp),
        .auto_speed_i  (auto_speed),
        .man_valid_i   (man_valid),
        .man_speed_i   (man_speed),
        .man_ready_o   (man_ready),
        .man_release_i (man_release),
        .speed_o       (speed),
        .mode_o        (mode),
        .emerg_flag_o  (emerg_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        cyc += n;
        #1;
    endtask

    task automatic to_tick();
        clocks(5 - cyc % 5);
    endtask

    task automatic st(input string tag, input int m, input int s);
        check({tag, "_mode"}, int'(mode), m);
        check({tag, "_speed"}, int'(speed), s);
    endtask

    initial begin
        #2;
        check("rst_speed", int'(speed), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_flag", int'(emerg_flag), 0);
        check("rst_ready", int'(man_ready), 1);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc = 0;
        clocks(4);
        st("pre_kick", 0, 0);
        clocks(1);
        st("kick", 3, 2048);
        check("kick_ready", int'(man_ready), 0);
        to_tick();
        st("kick_t1", 3, 2048);
        to_tick();
        st("kick_done", 0, 2048);
        to_tick();
        st("slew1", 0, 2032);
        clocks(600);
        st("slew121", 0, 112);
        to_tick();
        st("slew_last", 0, 100);
        to_tick();
        st("slew_hold", 0, 100);

        man_valid = 1'b1; man_speed = 12'd500; #1;
        check("auto_ready", int'(man_ready), 1);
        clocks(1);
        man_valid = 1'b0;
        st("man_acc", 1, 100);
        to_tick(); st("man_t1", 1, 116);
        to_tick(); st("man_t2", 1, 132);
        to_tick(); st("man_t3", 1, 148);
        to_tick(); st("man_timeout", 0, 164);
        to_tick(); st("auto_back", 0, 148);

        man_valid = 1'b1; man_speed = 12'd1000;
        clocks(1);
        man_valid = 1'b0;
        check("man2_mode", int'(mode), 1);
        temp = 12'd3199;
        clocks(1);
        check("temp3199_mode", int'(mode), 1);
        temp = 12'd3200;
        clocks(1);
        st("emerg", 2, 4095);
        check("emerg_flag", int'(emerg_flag), 1);
        check("emerg_ready", int'(man_ready), 0);
        man_valid = 1'b1;
        clocks(2);
        man_valid = 1'b0;
        st("emerg_valid_ign", 2, 4095);
        temp = 12'd3100;
        clocks(1);
        st("emerg_3100", 2, 4095);
        temp = 12'd3072;
        clocks(1);
        check("emerg_3072_flag", int'(emerg_flag), 1);
        temp = 12'd3071;
        clocks(1);
        st("emerg_exit", 0, 4095);
        check("exit_flag", int'(emerg_flag), 0);
        check("exit_ready", int'(man_ready), 1);
        to_tick();
        st("exit_slew", 0, 4079);

        man_valid = 1'b1; man_speed = 12'd4095;
        clocks(1);
        man_valid = 1'b0;
        check("man3_mode", int'(mode), 1);
        to_tick(); st("man3_t1", 1, 4095);
        to_tick(); st("man3_t2", 1, 4095);
        man_valid = 1'b1; man_speed = 12'd200; man_release = 1'b1;
        clocks(1);
        man_valid = 1'b0; man_release = 1'b0;
        st("acc_rel", 1, 4095);
        to_tick(); st("rel_t1", 1, 4079);
        to_tick(); st("rel_t2", 1, 4063);
        to_tick(); st("rel_t3", 1, 4047);
        to_tick(); st("rel_t4", 0, 4031);
        to_tick(); st("rel_auto", 0, 4015);

        man_valid = 1'b1; man_speed = 12'd1234;
        clocks(1);
        man_valid = 1'b0;
        check("man4_mode", int'(mode), 1);
        #3 rstn = 1'b0;
        #1;
        st("async_rst", 0, 0);
        check("async_flag", int'(emerg_flag), 0);
        check("async_ready", int'(man_ready), 1);
        clocks(2);
        st("rst_hold", 0, 0);
        auto_speed = 12'd3000;
        rstn = 1'b1;
        cyc = 0;
        clocks(4);
        st("rekick_pre", 0, 0);
        clocks(1);
        st("rekick", 3, 3000);
        temp = 12'd3200;
        clocks(1);
        st("kick_preempt", 2, 4095);
        temp = 12'd1000;
        clocks(1);
        st("preempt_exit", 0, 4095);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
